lsu_mem_ctrl: RTL and testbench

- Load/store sequencer between the core's memory stage and the byte-lane word RAM.
- Accepts one byte-addressed RV32I load/store per valid/ready handshake and converts it into word-addressed RAM accesses with byte enables.
- Splits word-crossing (misaligned) accesses into two consecutive word accesses, then merges, shifts and sign-extends load data.
- Returns a registered response through a valid/ready handshake.

---
 rtl/lsu_mem_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: byte-addressed RV32I load/store sequencer in front of a word RAM with byte lanes.
// Latency: error response after 1 cycle, aligned access 2 cycles, word-crossing access 3 cycles.
// Backpressure: a single request is in flight at a time; req_ready drops until the response handshake completes.
//
// Ports:
//   clk, rst (async, active high), clk_en (freezes every flop when low)
//   req_*  : valid/ready request (we, funct3, byte addr, right-aligned wdata)
//   resp_* : valid/ready response (extended load data, error flag)
//   mem_*  : registered RAM control; read data returns combinationally from mem_read_addr
module lsu_mem_ctrl #(
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read_req,
    output logic [ADDR_W-3:0] mem_read_addr,
    input  logic [31:0]       mem_read_data,
    output logic              mem_write_enable,
    output logic [3:0]        mem_byte_enable,
    output logic [ADDR_W-3:0] mem_write_addr,
    output logic [31:0]       mem_write_data
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    localparam logic [ADDR_W-3:0] WORD_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         lo_q, lo_d;

    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic                mem_read_req_q, mem_read_req_d;
    logic [ADDR_W-3:0]   mem_read_addr_q, mem_read_addr_d;
    logic                mem_write_enable_q, mem_write_enable_d;
    logic [3:0]          mem_byte_enable_q, mem_byte_enable_d;
    logic [ADDR_W-3:0]   mem_write_addr_q, mem_write_addr_d;
    logic [31:0]         mem_write_data_q, mem_write_data_d;

    // The operation being decoded: the live request while IDLE, the latched one afterwards.
    logic                cur_we;
    logic [2:0]          cur_funct3;
    logic [ADDR_W-1:0]   cur_addr;
    logic [31:0]         cur_wdata;
    logic [2:0]          cur_size;
    logic [3:0]          cur_lanes;
    logic [3:0]          cur_end;
    logic                cur_mis;
    logic                cur_illegal;
    logic [7:0]          cur_mask;
    logic [63:0]         cur_data64;
    logic [ADDR_W-3:0]   cur_word;
    logic [ADDR_W-3:0]   cur_word_nxt;

    assign cur_we     = (state_q == IDLE) ? req_we     : we_q;
    assign cur_funct3 = (state_q == IDLE) ? req_funct3 : funct3_q;
    assign cur_addr   = (state_q == IDLE) ? req_addr   : addr_q;
    assign cur_wdata  = (state_q == IDLE) ? req_wdata  : wdata_q;

    always_comb begin
        cur_size  = 3'd4;
        cur_lanes = 4'b1111;
        case (cur_funct3[1:0])
            2'b00: begin cur_size = 3'd1; cur_lanes = 4'b0001; end
            2'b01: begin cur_size = 3'd2; cur_lanes = 4'b0011; end
            default: begin cur_size = 3'd4; cur_lanes = 4'b1111; end
        endcase
    end

    assign cur_end      = {2'b00, cur_addr[1:0]} + {1'b0, cur_size};
    assign cur_mis      = (cur_end > 4'd4);
    assign cur_illegal  = (cur_funct3[1:0] == 2'b11) || (cur_we && cur_funct3[2]);
    // Lanes and data for both words at once; the upper half is the second word of a split store.
    assign cur_mask     = {4'b0000, cur_lanes} << cur_addr[1:0];
    assign cur_data64   = {32'h0, cur_wdata} << {cur_addr[1:0], 3'b000};
    assign cur_word     = cur_addr[ADDR_W-1:2];
    assign cur_word_nxt = cur_word + WORD_ONE;   // wraps from all-ones to zero

    function automatic logic [31:0] load_ext(input logic [63:0] pair,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
        logic [31:0] sh;
        sh = 32'(pair >> {off, 3'b000});
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    always_comb begin
        state_d            = state_q;
        we_d               = we_q;
        funct3_d           = funct3_q;
        addr_d             = addr_q;
        wdata_d            = wdata_q;
        lo_d               = lo_q;
        req_ready_d        = req_ready_q;
        resp_valid_d       = resp_valid_q;
        resp_err_d         = resp_err_q;
        resp_rdata_d       = resp_rdata_q;
        mem_read_req_d     = mem_read_req_q;
        mem_read_addr_d    = mem_read_addr_q;
        mem_write_enable_d = mem_write_enable_q;
        mem_byte_enable_d  = mem_byte_enable_q;
        mem_write_addr_d   = mem_write_addr_q;
        mem_write_data_d   = mem_write_data_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    funct3_d    = req_funct3;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (cur_illegal || (cur_mis && !ALLOW_MISALIGNED)) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        // First word's controls are registered here so they are live throughout ACC0.
                        state_d            = ACC0;
                        mem_read_req_d     = !req_we;
                        mem_read_addr_d    = cur_word;
                        mem_write_enable_d = req_we;
                        mem_byte_enable_d  = req_we ? cur_mask[3:0] : 4'b0000;
                        mem_write_addr_d   = cur_word;
                        mem_write_data_d   = req_we ? cur_data64[31:0] : 32'h0;
                    end
                end
            end
            ACC0: begin
                if (cur_mis) begin
                    state_d           = ACC1;
                    lo_d              = mem_read_data;
                    mem_read_addr_d   = cur_word_nxt;
                    mem_write_addr_d  = cur_word_nxt;
                    mem_byte_enable_d = we_q ? cur_mask[7:4] : 4'b0000;
                    mem_write_data_d  = we_q ? cur_data64[63:32] : 32'h0;
                end else begin
                    state_d            = RESP;
                    mem_read_req_d     = 1'b0;
                    mem_read_addr_d    = '0;
                    mem_write_enable_d = 1'b0;
                    mem_byte_enable_d  = 4'b0000;
                    mem_write_addr_d   = '0;
                    mem_write_data_d   = 32'h0;
                    resp_valid_d       = 1'b1;
                    resp_err_d         = 1'b0;
                    resp_rdata_d       = we_q ? 32'h0
                                              : load_ext({32'h0, mem_read_data}, addr_q[1:0], funct3_q);
                end
            end
            ACC1: begin
                state_d            = RESP;
                mem_read_req_d     = 1'b0;
                mem_read_addr_d    = '0;
                mem_write_enable_d = 1'b0;
                mem_byte_enable_d  = 4'b0000;
                mem_write_addr_d   = '0;
                mem_write_data_d   = 32'h0;
                resp_valid_d       = 1'b1;
                resp_err_d         = 1'b0;
                resp_rdata_d       = we_q ? 32'h0
                                          : load_ext({mem_read_data, lo_q}, addr_q[1:0], funct3_q);
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= IDLE;
            we_q               <= 1'b0;
            funct3_q           <= 3'b000;
            addr_q             <= '0;
            wdata_q            <= 32'h0;
            lo_q               <= 32'h0;
            req_ready_q        <= 1'b1;
            resp_valid_q       <= 1'b0;
            resp_err_q         <= 1'b0;
            resp_rdata_q       <= 32'h0;
            mem_read_req_q     <= 1'b0;
            mem_read_addr_q    <= '0;
            mem_write_enable_q <= 1'b0;
            mem_byte_enable_q  <= 4'b0000;
            mem_write_addr_q   <= '0;
            mem_write_data_q   <= 32'h0;
        end else if (clk_en) begin
            state_q            <= state_d;
            we_q               <= we_d;
            funct3_q           <= funct3_d;
            addr_q             <= addr_d;
            wdata_q            <= wdata_d;
            lo_q               <= lo_d;
            req_ready_q        <= req_ready_d;
            resp_valid_q       <= resp_valid_d;
            resp_err_q         <= resp_err_d;
            resp_rdata_q       <= resp_rdata_d;
            mem_read_req_q     <= mem_read_req_d;
            mem_read_addr_q    <= mem_read_addr_d;
            mem_write_enable_q <= mem_write_enable_d;
            mem_byte_enable_q  <= mem_byte_enable_d;
            mem_write_addr_q   <= mem_write_addr_d;
            mem_write_data_q   <= mem_write_data_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_err         = resp_err_q;
    assign resp_rdata       = resp_rdata_q;
    assign mem_read_req     = mem_read_req_q;
    assign mem_read_addr    = mem_read_addr_q;
    assign mem_write_enable = mem_write_enable_q;
    assign mem_byte_enable  = mem_byte_enable_q;
    assign mem_write_addr   = mem_write_addr_q;
    assign mem_write_data   = mem_write_data_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed vectors, corner sequences and random traffic against a byte-level memory model.
// Two instances: one splitting word-crossing accesses, one rejecting them.
module tb_lsu_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clk_en, sel, rnd_en;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        req_valid1, req_ready1, resp_valid1, resp_ready1, resp_err1;
    logic [31:0] resp_rdata1, mem_read_data1, mem_write_data1;
    logic        mem_read_req1, mem_write_enable1;
    logic [29:0] mem_read_addr1, mem_write_addr1;
    logic [3:0]  mem_byte_enable1;

    logic        req_valid2, req_ready2, resp_valid2, resp_ready2, resp_err2;
    logic [31:0] resp_rdata2, mem_write_data2;
    logic [31:0] mem_read_data2;
    logic        mem_read_req2, mem_write_enable2;
    logic [29:0] mem_read_addr2, mem_write_addr2;
    logic [3:0]  mem_byte_enable2;

    assign mem_read_data2 = 32'h0;

    lsu_mem_ctrl #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
        .mem_read_req(mem_read_req1), .mem_read_addr(mem_read_addr1), .mem_read_data(mem_read_data1),
        .mem_write_enable(mem_write_enable1), .mem_byte_enable(mem_byte_enable1),
        .mem_write_addr(mem_write_addr1), .mem_write_data(mem_write_data1)
    );

    lsu_mem_ctrl #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_strict (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid2), .resp_ready(resp_ready2), .resp_rdata(resp_rdata2), .resp_err(resp_err2),
        .mem_read_req(mem_read_req2), .mem_read_addr(mem_read_addr2), .mem_read_data(mem_read_data2),
        .mem_write_enable(mem_write_enable2), .mem_byte_enable(mem_byte_enable2),
        .mem_write_addr(mem_write_addr2), .mem_write_data(mem_write_data2)
    );

    logic        req_ready_m, resp_valid_m, resp_err_m;
    logic [31:0] resp_rdata_m;
    assign req_ready_m  = sel ? req_ready2  : req_ready1;
    assign resp_valid_m = sel ? resp_valid2 : resp_valid1;
    assign resp_err_m   = sel ? resp_err2   : resp_err1;
    assign resp_rdata_m = sel ? resp_rdata2 : resp_rdata1;

    // 64-word RAM; word index aliases modulo 64 so byte address maps to byte (addr mod 256).
    logic [31:0] ram [0:63];
    logic [7:0]  refb [0:255];
    int          wr_cnt1 = 0, wr_cnt2 = 0;
    logic [29:0] wl_a[$];
    logic [3:0]  wl_b[$];
    logic [31:0] wl_d[$];

    always_comb mem_read_data1 = ram[mem_read_addr1[5:0]];

    always @(posedge clk) begin
        if (clk_en && mem_write_enable1) begin
            for (int b = 0; b < 4; b++)
                if (mem_byte_enable1[b]) ram[mem_write_addr1[5:0]][8*b +: 8] <= mem_write_data1[8*b +: 8];
            wr_cnt1 <= wr_cnt1 + 1;
            wl_a.push_back(mem_write_addr1);
            wl_b.push_back(mem_byte_enable1);
            wl_d.push_back(mem_write_data1);
        end
        if (clk_en && mem_write_enable2) wr_cnt2 <= wr_cnt2 + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic en_pick();
        return rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    // ---------------- reference model (byte granular) ----------------
    function automatic int m_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic m_mis(input logic [31:0] a, input logic [2:0] f3);
        return (int'(a[1:0]) + m_size(f3)) > 4;
    endfunction

    function automatic logic m_err(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic allow);
        return (f3[1:0] == 2'b11) || (we && f3[2]) || (!allow && m_mis(a, f3));
    endfunction

    // limit: how many bytes actually reach memory (a store cut short by reset)
    task automatic m_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd, input int limit);
        for (int i = 0; i < m_size(f3) && i < limit; i++)
            refb[8'(a + 32'(i))] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < m_size(f3); i++) v[8*i +: 8] = refb[8'(a + 32'(i))];
        if (m_size(f3) == 1 && !f3[2]) v = {{24{v[7]}}, v[7:0]};
        if (m_size(f3) == 2 && !f3[2]) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    // ---------------- one full request/response transaction ----------------
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input int hold, output logic [31:0] rd, output logic er, output int lat, output int nwr);
        int   w0, guard;
        logic hs, ok_hold;
        w0 = sel ? wr_cnt2 : wr_cnt1;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        if (sel) req_valid2 = 1'b1; else req_valid1 = 1'b1;
        guard = 0;
        forever begin
            clk_en = en_pick();
            hs = req_ready_m && clk_en;
            cycle();
            if (hs) break;
            guard++;
            if (guard > 50) begin chk("req_handshake_timeout", 32'h0, 32'h1); break; end
        end
        req_valid1 = 1'b0; req_valid2 = 1'b0;
        lat = 1;
        while (!resp_valid_m && lat < 60) begin
            clk_en = en_pick();
            cycle();
            lat++;
        end
        if (!resp_valid_m) chk("resp_timeout", 32'h0, 32'h1);
        rd = resp_rdata_m;
        er = resp_err_m;
        ok_hold = 1'b1;
        for (int h = 0; h < hold; h++) begin
            clk_en = en_pick();
            cycle();
            if (!resp_valid_m || resp_rdata_m !== rd || resp_err_m !== er || req_ready_m) ok_hold = 1'b0;
        end
        if (hold > 0) chk("resp_hold_stable", 32'(ok_hold), 32'h1);
        if (sel) resp_ready2 = 1'b1; else resp_ready1 = 1'b1;
        guard = 0;
        forever begin
            clk_en = en_pick();
            hs = clk_en;
            cycle();
            if (hs) break;
            guard++;
            if (guard > 50) begin chk("resp_handshake_timeout", 32'h0, 32'h1); break; end
        end
        resp_ready1 = 1'b0; resp_ready2 = 1'b0;
        clk_en = 1'b1;
        nwr = (sel ? wr_cnt2 : wr_cnt1) - w0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
        string       nm;
    } vec_t;

    vec_t tbl [19];

    initial begin
        logic [31:0] rd, a, wd, exp_rd;
        logic        er, we, ok, exp_er;
        logic [2:0]  f3;
        int          lat, nwr, hold;

        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        for (int i = 0; i < 256; i++) refb[i] = 8'h0;
        sel = 1'b0; rnd_en = 1'b0; clk_en = 1'b1; rst = 1'b1;
        req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        req_valid1 = 1'b0; req_valid2 = 1'b0; resp_ready1 = 1'b0; resp_ready2 = 1'b0;

        tbl[0]  = '{1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1, "sw_aligned"};
        tbl[1]  = '{1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 2, 0, "lw_aligned"};
        tbl[2]  = '{1'b1, 3'b000, 32'h13,       32'h000000A5, 32'h00000000, 1'b0, 2, 1, "sb_lane3"};
        tbl[3]  = '{1'b0, 3'b000, 32'h13,       32'h0,        32'hFFFFFFA5, 1'b0, 2, 0, "lb_sext"};
        tbl[4]  = '{1'b0, 3'b100, 32'h13,       32'h0,        32'h000000A5, 1'b0, 2, 0, "lbu_zext"};
        tbl[5]  = '{1'b1, 3'b010, 32'h0E,       32'h11223344, 32'h00000000, 1'b0, 3, 2, "sw_split"};
        tbl[6]  = '{1'b0, 3'b010, 32'h0E,       32'h0,        32'h11223344, 1'b0, 3, 0, "lw_split"};
        tbl[7]  = '{1'b0, 3'b101, 32'h12,       32'h0,        32'h0000A5AD, 1'b0, 2, 0, "lhu_hi_half"};
        tbl[8]  = '{1'b0, 3'b001, 32'h12,       32'h0,        32'hFFFFA5AD, 1'b0, 2, 0, "lh_hi_half"};
        tbl[9]  = '{1'b0, 3'b000, 32'h11,       32'h0,        32'h00000011, 1'b0, 2, 0, "lb_lane1"};
        tbl[10] = '{1'b0, 3'b011, 32'h10,       32'h0,        32'h00000000, 1'b1, 1, 0, "ld_funct3_011"};
        tbl[11] = '{1'b1, 3'b100, 32'h10,       32'h000000FF, 32'h00000000, 1'b1, 1, 0, "st_funct3_100"};
        tbl[12] = '{1'b0, 3'b100, 32'h10,       32'h0,        32'h00000022, 1'b0, 2, 0, "lbu_after_bad_st"};
        tbl[13] = '{1'b1, 3'b000, 32'h00,       32'h00000080, 32'h00000000, 1'b0, 2, 1, "sb_word0"};
        tbl[14] = '{1'b1, 3'b000, 32'hFFFFFFFF, 32'h0000007F, 32'h00000000, 1'b0, 2, 1, "sb_top_byte"};
        tbl[15] = '{1'b0, 3'b001, 32'hFFFFFFFF, 32'h0,        32'hFFFF807F, 1'b0, 3, 0, "lh_wrap"};
        tbl[16] = '{1'b1, 3'b001, 32'h0F,       32'h0000BEEF, 32'h00000000, 1'b0, 3, 2, "sh_split"};
        tbl[17] = '{1'b0, 3'b101, 32'h0F,       32'h0,        32'h0000BEEF, 1'b0, 3, 0, "lhu_split"};
        tbl[18] = '{1'b0, 3'b010, 32'h0D,       32'h0,        32'hBEEF4400, 1'b0, 3, 0, "lw_split_off1"};

        // reset values
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready1), 32'h1);
        chk("rst_resp", {resp_valid1, resp_err1, mem_read_req1, mem_write_enable1, mem_byte_enable1}, 32'h0);
        chk("rst_rdata", resp_rdata1, 32'h0);
        chk("rst_mem_addr_data", {mem_read_addr1 | mem_write_addr1, 2'b00} | mem_write_data1, 32'h0);
        rst = 1'b0;
        cycle();
        chk("idle_req_ready", 32'(req_ready1), 32'h1);

        // directed vector table
        for (int i = 0; i < 19; i++) begin
            wl_a.delete(); wl_b.delete(); wl_d.delete();
            do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, i % 3, rd, er, lat, nwr);
            chk({tbl[i].nm, "_rdata"}, rd, tbl[i].exp_rdata);
            chk({tbl[i].nm, "_err"}, 32'(er), 32'(tbl[i].exp_err));
            chk({tbl[i].nm, "_latency"}, lat, tbl[i].exp_lat);
            chk({tbl[i].nm, "_writes"}, nwr, tbl[i].exp_wr);
            if (!m_err(tbl[i].we, tbl[i].f3, tbl[i].addr, 1'b1) && tbl[i].we)
                m_store(tbl[i].addr, tbl[i].f3, tbl[i].wdata, 4);
            if (i == 0) begin
                chk("sw_aligned_beat0", {wl_a[0], 2'b00}, 32'h10);
                chk("sw_aligned_be0", 32'(wl_b[0]), 32'hF);
                chk("sw_aligned_data0", wl_d[0], 32'hDEADBEEF);
            end
            if (i == 2) begin
                chk("sb_lane3_be", 32'(wl_b[0]), 32'h8);
                chk("sb_lane3_data", wl_d[0], 32'hA5000000);
            end
            if (i == 5) begin
                chk("sw_split_n", wl_a.size(), 2);
                chk("sw_split_word0", 32'(wl_a[0]), 32'h3);
                chk("sw_split_be0", 32'(wl_b[0]), 32'hC);
                chk("sw_split_data0", wl_d[0], 32'h33440000);
                chk("sw_split_word1", 32'(wl_a[1]), 32'h4);
                chk("sw_split_be1", 32'(wl_b[1]), 32'h3);
                chk("sw_split_data1", wl_d[1], 32'h00001122);
            end
        end

        // instance that rejects word-crossing accesses
        sel = 1'b1;
        do_req(1'b1, 3'b010, 32'h0E, 32'h11223344, 0, rd, er, lat, nwr);
        chk("strict_sw_mis_err", 32'(er), 32'h1);
        chk("strict_sw_mis_lat", lat, 1);
        chk("strict_sw_mis_writes", nwr, 0);
        do_req(1'b0, 3'b001, 32'h13, 32'h0, 0, rd, er, lat, nwr);
        chk("strict_lh_mis_err", 32'(er), 32'h1);
        chk("strict_lh_mis_rdata", rd, 32'h0);
        do_req(1'b1, 3'b010, 32'h10, 32'h5, 0, rd, er, lat, nwr);
        chk("strict_sw_ok_err", 32'(er), 32'h0);
        chk("strict_sw_ok_lat", lat, 2);
        chk("strict_sw_ok_writes", nwr, 1);
        sel = 1'b0;

        // clk_en low during ACC0, then response held with a competing request pending
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        req_valid1 = 1'b1;
        chk("freeze_ready_before", 32'(req_ready1), 32'h1);
        cycle();
        req_valid1 = 1'b0;
        chk("freeze_acc0_rd", {mem_read_addr1, 1'b0, mem_read_req1}, {30'h4, 2'b01});
        clk_en = 1'b0;
        ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            if (!mem_read_req1 || mem_read_addr1 !== 30'h4 || resp_valid1) ok = 1'b0;
        end
        chk("freeze_acc0_hold", 32'(ok), 32'h1);
        clk_en = 1'b1;
        cycle();
        chk("freeze_resp_valid", 32'(resp_valid1), 32'h1);
        exp_rd = m_load(32'h10, 3'b010);
        chk("freeze_resp_rdata", resp_rdata1, exp_rd);
        req_valid1 = 1'b1; req_addr = 32'h20;
        ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            clk_en = c[0];
            cycle();
            if (!resp_valid1 || resp_rdata1 !== exp_rd || req_ready1 || mem_read_req1 || mem_write_enable1)
                ok = 1'b0;
        end
        chk("stall_resp_stable", 32'(ok), 32'h1);
        req_valid1 = 1'b0; clk_en = 1'b1; resp_ready1 = 1'b1;
        cycle();
        resp_ready1 = 1'b0;
        chk("stall_release", {resp_valid1, req_ready1}, 32'h1);

        // reset while the second word of a split store is pending
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h1E; req_wdata = 32'hCAFEF00D;
        req_valid1 = 1'b1;
        cycle();
        req_valid1 = 1'b0;
        chk("rstmid_acc0", {mem_write_addr1, mem_byte_enable1[1:0]}, {30'h7, 2'b00});
        chk("rstmid_acc0_data", mem_write_data1, 32'hF00D0000);
        cycle();
        chk("rstmid_acc1", {mem_write_addr1, mem_byte_enable1[1:0]}, {30'h8, 2'b11});
        chk("rstmid_acc1_data", mem_write_data1, 32'h0000CAFE);
        rst = 1'b1;
        #1;
        chk("rstmid_outs", {resp_valid1, resp_err1, mem_read_req1, mem_write_enable1, mem_byte_enable1}, 32'h0);
        chk("rstmid_buses", resp_rdata1 | mem_write_data1 | {mem_read_addr1 | mem_write_addr1, 2'b00}, 32'h0);
        chk("rstmid_ready", 32'(req_ready1), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        m_store(32'h1E, 3'b010, 32'hCAFEF00D, 2);
        cycle();
        chk("rstmid_ready_after", 32'(req_ready1), 32'h1);
        do_req(1'b0, 3'b010, 32'h1C, 32'h0, 0, rd, er, lat, nwr);
        chk("rstmid_readback", rd, m_load(32'h1C, 3'b010));

        // random traffic with random clk_en gaps and response stalls
        rnd_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'b011) f3 = 3'b101;
            end
            if ($urandom_range(0, 9) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else a = 32'($urandom_range(0, 127));
            wd = $urandom;
            hold = $urandom_range(0, 3);
            exp_er = m_err(we, f3, a, 1'b1);
            exp_rd = (exp_er || we) ? 32'h0 : m_load(a, f3);
            do_req(we, f3, a, wd, hold, rd, er, lat, nwr);
            chk("rnd_err", 32'(er), 32'(exp_er));
            chk("rnd_rdata", rd, exp_rd);
            chk("rnd_writes", nwr, (exp_er || !we) ? 0 : (m_mis(a, f3) ? 2 : 1));
            if (!exp_er && we) m_store(a, f3, wd, 4);
        end
        rnd_en = 1'b0; clk_en = 1'b1;

        // final memory image
        for (int w = 0; w < 64; w++)
            chk($sformatf("ram_word_%0d", w), ram[w], {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
